dpwm_gen: RTL and testbench



---
 rtl/dpwm_gen.sv | 109 ++++++++++
 tb/tb_dpwm_gen.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/dpwm_gen.sv
// dpwm_gen: counter-comparator digital PWM generator with clock prescaler.
//
// This block consumes the 3-bit duty code from the up/down duty counter and drives the
// PWM pin/LED driver. A prescaler divides clkm into ticks. A phase counter steps once per
// tick through 2^DUTY_W phases. The output is high while phase < duty_active. duty_in is
// shadow-latched only at period boundaries, so a duty step never truncates or glitches a pulse.
//
// Ports:
//   clkm         - system clock; all state changes on its rising edge
//   reset        - asynchronous, active-high; clears all state
//   en           - run enable, sampled on clkm
//   duty_in      - requested duty code (high ticks out of 2^DUTY_W)
//   pwm_out      - registered PWM waveform
//   period_start - one-clkm pulse on the first cycle of phase 0
//   duty_active  - duty code currently in force (shadow register)
module dpwm_gen #(
    parameter int unsigned DUTY_W    = 3,
    parameter int unsigned PRESC_DIV = 4,
    parameter int unsigned PRESC_W   = 8
) (
    input  logic              clkm,
    input  logic              reset,
    input  logic              en,
    input  logic [DUTY_W-1:0] duty_in,
    output logic              pwm_out,
    output logic              period_start,
    output logic [DUTY_W-1:0] duty_active
);

    localparam logic StIdle = 1'b0;
    localparam logic StRun  = 1'b1;

    localparam logic [PRESC_W-1:0] PrescLast = PRESC_W'(PRESC_DIV - 1);
    localparam logic [DUTY_W-1:0]  PhaseLast = {DUTY_W{1'b1}};

    logic               state_q, state_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [DUTY_W-1:0]  phase_q, phase_d;
    logic [DUTY_W-1:0]  duty_q, duty_d;
    logic               pwm_q, pwm_d;
    logic               pstart_q, pstart_d;
    logic               tick;

    assign tick = (presc_q == PrescLast);

    always_comb begin
        state_d  = state_q;
        presc_d  = '0;
        phase_d  = '0;
        duty_d   = duty_q;
        pstart_d = 1'b0;

        case (state_q)
            StIdle: begin
                // Starting always opens a fresh period with the requested duty.
                if (en) begin
                    state_d  = StRun;
                    duty_d   = duty_in;
                    pstart_d = 1'b1;
                end
            end
            StRun: begin
                // Dropping en abandons the period at once, even on a boundary edge.
                if (!en) begin
                    state_d = StIdle;
                end else begin
                    presc_d = tick ? '0 : presc_q + 1'b1;
                    phase_d = phase_q;
                    if (tick) begin
                        phase_d = phase_q + 1'b1;  // wraps to 0 after the last phase
                        if (phase_q == PhaseLast) begin
                            duty_d   = duty_in;
                            pstart_d = 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Compare against next-state values so pwm_out is registered yet in step with phase.
        pwm_d = (state_d == StRun) && (phase_d < duty_d);
    end

    always_ff @(posedge clkm or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            presc_q  <= '0;
            phase_q  <= '0;
            duty_q   <= '0;
            pwm_q    <= 1'b0;
            pstart_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            presc_q  <= presc_d;
            phase_q  <= phase_d;
            duty_q   <= duty_d;
            pwm_q    <= pwm_d;
            pstart_q <= pstart_d;
        end
    end

    assign pwm_out      = pwm_q;
    assign period_start = pstart_q;
    assign duty_active  = duty_q;

endmodule

// File: tb/tb_dpwm_gen.sv
// tb_dpwm_gen: scoreboard bench for dpwm_gen.
// Two instances share clkm/reset: u_dut_a uses PRESC_DIV=4 and u_dut_b uses PRESC_DIV=1.
// The stimulus pushes one hand-computed record per complete period it expects.
// A monitor closes each period at the next period_start and compares it to the queue head.
module tb_dpwm_gen;

    typedef struct {
        int duty;  // duty_active on the period's first cycle
        int hi;    // pwm_out high cycles in the period
        int len;   // clkm cycles from period_start to next period_start
        int hi0;   // pwm_out on the period's first cycle
    } per_t;

    logic       clkm = 1'b0;
    logic       reset;
    logic       en_a, en_b;
    logic [2:0] duty_a, duty_b;
    logic       pwm_a, pwm_b, ps_a, ps_b;
    logic [2:0] da_a, da_b;
    logic       en_seen_a = 1'b0;
    logic       en_seen_b = 1'b0;

    int   n_chk  = 0;
    int   n_fail = 0;
    per_t q_a[$];
    per_t q_b[$];
    int   trk[2], hi[2], len[2], cur[2], h0[2];

    dpwm_gen #(.DUTY_W(3), .PRESC_DIV(4), .PRESC_W(8)) u_dut_a (
        .clkm(clkm), .reset(reset), .en(en_a), .duty_in(duty_a),
        .pwm_out(pwm_a), .period_start(ps_a), .duty_active(da_a)
    );

    dpwm_gen #(.DUTY_W(3), .PRESC_DIV(1), .PRESC_W(8)) u_dut_b (
        .clkm(clkm), .reset(reset), .en(en_b), .duty_in(duty_b),
        .pwm_out(pwm_b), .period_start(ps_b), .duty_active(da_b)
    );

    always #5 clkm = ~clkm;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clkm);
        #2;
    endtask

    // Waits up to max negedges for period_start of instance m.
    task automatic wait_ps(input int m, input int max, output int seen);
        seen = 0;
        for (int i = 0; i < max; i++) begin
            @(negedge clkm);
            if ((m == 0) ? ps_a : ps_b) begin
                seen = 1;
                break;
            end
        end
    endtask

    // One monitor step for instance m; a partial period is dropped when the block leaves RUN.
    task automatic mon(input int m, input logic abort, input logic ps, input logic pwm,
                       input int da);
        per_t e;
        int   avail;
        if (abort) begin
            trk[m] = 0;
            return;
        end
        if (ps) begin
            if (trk[m] != 0) begin
                avail = (m == 0) ? q_a.size() : q_b.size();
                if (avail == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL m%0d_unexpected_period: got duty %0d hi %0d len %0d, expected none",
                             m, cur[m], hi[m], len[m]);
                end else begin
                    e = (m == 0) ? q_a.pop_front() : q_b.pop_front();
                    check($sformatf("m%0d_period_duty", m), cur[m], e.duty);
                    check($sformatf("m%0d_period_high", m), hi[m], e.hi);
                    check($sformatf("m%0d_period_len", m), len[m], e.len);
                    check($sformatf("m%0d_period_first_pwm", m), h0[m], e.hi0);
                end
            end
            trk[m] = 1;
            cur[m] = da;
            hi[m]  = 0;
            len[m] = 0;
            h0[m]  = int'(pwm);
        end
        if (trk[m] != 0) begin
            len[m]++;
            if (pwm) hi[m]++;
        end
    endtask

    always @(posedge clkm) begin
        en_seen_a <= en_a;
        en_seen_b <= en_b;
    end

    always @(negedge clkm) begin
        mon(0, reset || !en_seen_a, ps_a, pwm_a, int'(da_a));
        mon(1, reset || !en_seen_b, ps_b, pwm_b, int'(da_b));
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        int got;
        for (int i = 0; i < 2; i++) trk[i] = 0;
        reset  = 1'b1;
        en_a   = 1'b0;
        en_b   = 1'b0;
        duty_a = 3'd0;
        duty_b = 3'd0;
        #1;
        check("reset_pwm", int'(pwm_a), 0);
        check("reset_pstart", int'(ps_a), 0);
        check("reset_duty", int'(da_a), 0);
        check("reset_pwm_b", int'(pwm_b), 0);
        step(2);
        reset = 1'b0;
        step(1);

        // Periods P1..P11 of instance A; PRESC_DIV=4 gives 32-cycle periods.
        for (int i = 0; i < 3; i++) q_a.push_back('{3, 12, 32, 1});
        for (int i = 0; i < 3; i++) q_a.push_back('{0, 0, 32, 0});
        for (int i = 0; i < 3; i++) q_a.push_back('{7, 28, 32, 1});
        q_a.push_back('{3, 12, 32, 1});
        q_a.push_back('{6, 24, 32, 1});
        duty_a = 3'd3;
        en_a   = 1'b1;
        @(posedge clkm);
        wait_ps(0, 1, got);
        check("t1_first_pstart", got, 1);
        check("t1_first_pwm", int'(pwm_a), 1);
        // Cycle numbers below count from the P1 start cycle (cycle 0).
        step(74);   duty_a = 3'd0;   // cycle 74, inside P3
        step(96);   duty_a = 3'd7;   // cycle 170, inside P6
        step(96);   duty_a = 3'd3;   // cycle 266, inside P9
        step(27);   duty_a = 3'd6;   // cycle 293, cycle 5 of P10
        step(69);                    // cycle 362, high part of P12
        check("t4_pwm_before_drop", int'(pwm_a), 1);
        en_a = 1'b0;
        @(posedge clkm);
        @(negedge clkm);
        check("t4_pwm_low", int'(pwm_a), 0);
        check("t4_no_pstart", int'(ps_a), 0);
        check("t4_duty_hold", int'(da_a), 6);

        q_a.push_back('{6, 24, 32, 1});
        q_a.push_back('{6, 24, 32, 1});
        step(2);
        en_a = 1'b1;
        @(posedge clkm);
        wait_ps(0, 1, got);
        check("t4_restart_pstart", got, 1);
        check("t4_restart_pwm", int'(pwm_a), 1);
        check("t4_restart_duty", int'(da_a), 6);
        step(34);   duty_a = 3'd5;   // loaded at the boundary that opens P15
        step(40);                    // cycle 10 of P15, duty 5, still high
        check("t5_pwm_before_reset", int'(pwm_a), 1);
        #1;
        reset = 1'b1;
        en_a  = 1'b0;
        #1;
        check("t5_async_pwm", int'(pwm_a), 0);
        check("t5_async_pstart", int'(ps_a), 0);
        check("t5_async_duty", int'(da_a), 0);
        step(2);
        reset = 1'b0;
        step(3);
        check("t5_idle_pwm", int'(pwm_a), 0);
        check("t5_idle_pstart", int'(ps_a), 0);
        q_a.push_back('{2, 8, 32, 1});
        duty_a = 3'd2;
        en_a   = 1'b1;
        @(posedge clkm);
        wait_ps(0, 1, got);
        check("t5_restart_pstart", got, 1);
        step(33);
        en_a = 1'b0;
        step(2);

        // Instance B: PRESC_DIV=1, duty 1, so there are 8-cycle periods with one high cycle.
        q_b.push_back('{1, 1, 8, 1});
        q_b.push_back('{1, 1, 8, 1});
        duty_b = 3'd1;
        en_b   = 1'b1;
        @(posedge clkm);
        wait_ps(1, 1, got);
        check("t6_first_pstart", got, 1);
        check("t6_first_pwm", int'(pwm_b), 1);
        step(23);                    // en falls on the edge that would open the fourth period
        en_b   = 1'b0;
        duty_b = 3'd5;
        @(posedge clkm);
        @(negedge clkm);
        check("t6_boundary_no_pstart", int'(ps_b), 0);
        check("t6_boundary_no_load", int'(da_b), 1);
        check("t6_boundary_pwm", int'(pwm_b), 0);
        step(2);

        check("queue_a_drained", q_a.size(), 0);
        check("queue_b_drained", q_b.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
